// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers {op, X, Y} commands in a small FIFO, issues them one
// at a time to a fixed-latency 16-bit ALU and returns each Z in command order over
// a valid/ready result interface.
// Build option: define ALU_SEQ_DIV0_EN to turn op 3 with Y == 0 into an immediate
// error result (Z = all ones, res_err = 1) without touching the ALU inputs.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   c,
    input  logic                   r,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [15:0]            cmd_x,
    input  logic [15:0]            cmd_y,
    output logic [3:0]             alu_s,
    output logic [15:0]            alu_x,
    output logic [15:0]            alu_y,
    input  logic [31:0]            alu_z,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_z,
    output logic [3:0]             res_op,
    output logic                   res_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(ALU_LAT + 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [35:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   lat_cnt;
    logic [3:0]      head_op;
    logic [15:0]     head_x;
    logic [15:0]     head_y;
    logic            fifo_empty;
    logic            head_div0;
    logic            push;
    logic            pop;
    logic            issue;
    logic            err_load;
    logic            capture;
    logic            release_res;

    assign fifo_empty = (fifo_count == '0);
    assign cmd_ready  = ~r & (fifo_count < FULL_CNT);
    assign push       = cmd_valid & cmd_ready;
    assign busy       = ~((state == S_IDLE) & fifo_empty);

    assign head_op = mem[rd_ptr][35:32];
    assign head_x  = mem[rd_ptr][31:16];
    assign head_y  = mem[rd_ptr][15:0];

`ifdef ALU_SEQ_DIV0_EN
    assign head_div0 = (head_op == 4'h3) & (head_y == 16'h0);
`else
    assign head_div0 = 1'b0;
`endif

    // a popped divide-by-zero becomes an error result; anything else goes to the ALU
    assign issue    = pop & ~head_div0;
    assign err_load = pop & head_div0;

    // FSM state register
    always_ff @(posedge c) begin
        if (r) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a popped error command skips WAIT and lands directly in HOLD
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = head_div0 ? S_HOLD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    if (pop) begin
                        state_nxt = head_div0 ? S_HOLD : S_WAIT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: when to pop the FIFO, capture Z, or retire the held result
    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            S_IDLE: pop = ~fifo_empty;
            S_WAIT: capture = (lat_cnt == '0);
            S_HOLD: begin
                release_res = res_ready;
                pop         = res_ready & ~fifo_empty;
            end
            default: ;
        endcase
    end

    // command FIFO: pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge c) begin
        if (r) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {cmd_op, cmd_x, cmd_y};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ALU drive and result capture; ALU inputs keep their last issued values when idle
    always_ff @(posedge c) begin
        if (r) begin
            alu_s     <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            lat_cnt   <= '0;
            res_valid <= 1'b0;
            res_z     <= '0;
            res_op    <= '0;
        end else begin
            if (issue) begin
                alu_s   <= head_op;
                alu_x   <= head_x;
                alu_y   <= head_y;
                lat_cnt <= LW'(ALU_LAT);
            end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LW'(1);
            end
            if (capture) begin
                res_z     <= alu_z;
                res_op    <= alu_s;
                res_valid <= 1'b1;
            end else if (err_load) begin
                res_z     <= 32'hFFFF_FFFF;
                res_op    <= 4'h3;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_DIV0_EN
    // error flag: set by a short-circuited divide-by-zero, cleared by any real capture
    always_ff @(posedge c) begin
        if (r) begin
            res_err <= 1'b0;
        end else if (capture) begin
            res_err <= 1'b0;
        end else if (err_load) begin
            res_err <= 1'b1;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a registered ALU stand-in, a transaction-level
// reference model (queue of pending commands plus issue/capture edge arithmetic),
// directed scenarios with literal expectations and a randomized soak.
module tb_alu_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic        c         = 1'b0;
    logic        r         = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op    = '0;
    logic [15:0] cmd_x     = '0;
    logic [15:0] cmd_y     = '0;
    logic        res_ready = 1'b0;
    logic        cmd_ready;
    logic [3:0]  alu_s;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [31:0] alu_z;
    logic        res_valid;
    logic [31:0] res_z;
    logic [3:0]  res_op;
    logic        res_err;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .c(c), .r(r), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
        .res_op(res_op), .res_err(res_err), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 c = ~c;

    function automatic logic [31:0] alu_func(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y);
        case (s)
            4'h0:    return 32'(x) + 32'(y);
            4'h1:    return 32'(x) - 32'(y);
            4'h2:    return 32'(x) * 32'(y);
            4'h3:    return (y == 16'h0) ? 32'h0 : 32'(x / y);
            4'h4:    return 32'(x & y);
            4'h5:    return 32'(x ^ y);
            4'hC:    return 32'(x | y);
            default: return {x, y} ^ 32'(s);
        endcase
    endfunction

    // ALU stand-in: Z follows the inputs after ALU_LAT edges
    logic [31:0] pipe [ALU_LAT];
    always @(posedge c) begin
        pipe[0] <= alu_func(alu_s, alu_x, alu_y);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_z = pipe[ALU_LAT-1];

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } cmd_t;

    cmd_t        mq[$];
    bit          m_inflight = 0;
    bit          m_holding  = 0;
    int          m_cap      = 0;
    int          m_edge     = 0;
    logic [31:0] m_z        = '0;
    logic [3:0]  m_op       = '0;
    logic        m_err      = 1'b0;
    logic [3:0]  m_s        = '0;
    logic [15:0] m_x        = '0;
    logic [15:0] m_y        = '0;

    function automatic bit is_div0(input cmd_t h);
`ifdef ALU_SEQ_DIV0_EN
        return (h.op == 4'h3) && (h.y == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: applied at each rising edge using the inputs driven before it
    task automatic model_update();
        bit   push_ok;
        cmd_t h;
        m_edge++;
        if (r) begin
            mq.delete();
            m_inflight = 0;
            m_holding  = 0;
            m_s = '0; m_x = '0; m_y = '0;
            m_z = '0; m_op = '0; m_err = 1'b0;
            return;
        end
        push_ok = cmd_valid && (mq.size() < DEPTH);
        if (m_holding && res_ready) m_holding = 0;
        if (m_inflight && (m_edge == m_cap)) begin
            m_inflight = 0;
            m_holding  = 1;
            m_z   = alu_func(m_s, m_x, m_y);
            m_op  = m_s;
            m_err = 1'b0;
        end
        if (!m_inflight && !m_holding && (mq.size() != 0)) begin
            h = mq.pop_front();
            if (is_div0(h)) begin
                m_holding = 1;
                m_z   = 32'hFFFF_FFFF;
                m_op  = 4'h3;
                m_err = 1'b1;
            end else begin
                m_s = h.op; m_x = h.x; m_y = h.y;
                m_inflight = 1;
                m_cap = m_edge + ALU_LAT + 1;
            end
        end
        if (push_ok) mq.push_back({cmd_op, cmd_x, cmd_y});
    endtask

    task automatic compare();
        chk("cmd_ready", 32'(cmd_ready), 32'(!r && (mq.size() < DEPTH)));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("busy", 32'(busy), 32'(m_inflight || m_holding || (mq.size() != 0)));
        chk("res_valid", 32'(res_valid), 32'(m_holding));
        chk("alu_s", 32'(alu_s), 32'(m_s));
        chk("alu_x", 32'(alu_x), 32'(m_x));
        chk("alu_y", 32'(alu_y), 32'(m_y));
        if (m_holding) begin
            chk("res_z", res_z, m_z);
            chk("res_op", 32'(res_op), 32'(m_op));
            chk("res_err", 32'(res_err), 32'(m_err));
        end
    endtask

    task automatic step();
        @(posedge c);
        model_update();
        @(negedge c);
        compare();
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
    endtask

    logic [3:0]  stream_ops [4];
    logic [31:0] stream_exp [4];
    logic [31:0] rz [4];
    int          ridx [4];
    int          nres;
    int          cnt;

    initial begin
        stream_ops[0] = 4'h1; stream_ops[1] = 4'h2; stream_ops[2] = 4'h3; stream_ops[3] = 4'hC;
        stream_exp[0] = 32'h14; stream_exp[1] = 32'h320; stream_exp[2] = 32'h2; stream_exp[3] = 32'h3C;

        // reset
        r = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_res_z", res_z, 32'h0);
        r = 1'b0;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 32'h1);

        // single add, 3-edge latency
        res_ready = 1'b1;
        drive(4'h0, 16'h28, 16'h14);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("add_early_valid", 32'(res_valid), 32'h0);
        step();
        chk("add_valid", 32'(res_valid), 32'h1);
        chk("add_z", res_z, 32'h3C);
        chk("add_op", 32'(res_op), 32'h0);
        step();
        step();

        // back-to-back stream
        nres = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= 4) drive(stream_ops[i-1], 16'h28, 16'h14);
            else cmd_valid = 1'b0;
            step();
            if (res_valid) begin
                if (nres < 4) begin
                    rz[nres]   = res_z;
                    ridx[nres] = i;
                end
                nres++;
            end
        end
        chk("stream_count", 32'(nres), 32'd4);
        if (nres >= 4) begin
            chk("stream_first_idx", 32'(ridx[0]), 32'd4);
            for (int k = 0; k < 4; k++) chk("stream_z", rz[k], stream_exp[k]);
            for (int k = 0; k < 3; k++) chk("stream_gap", 32'(ridx[k+1] - ridx[k]), 32'd3);
        end

        // backpressure
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'h0, 16'(i + 1), 16'(2 * i + 2));
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_fifo_full", 32'(fifo_count), 32'd4);
        chk("bp_ready_low", 32'(cmd_ready), 32'h0);
        chk("bp_first_z", res_z, 32'h3);
        step();
        step();
        step();
        chk("bp_hold_valid", 32'(res_valid), 32'h1);
        chk("bp_hold_z", res_z, 32'h3);
        res_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) cnt++;
            step();
        end
        chk("bp_drained", 32'(cnt), 32'd5);
        chk("bp_empty", 32'(fifo_count), 32'h0);

        // reset during WAIT
        drive(4'h2, 16'h28, 16'h14);
        step();
        cmd_valid = 1'b0;
        step();
        r = 1'b1;
        step();
        chk("rw_res_valid", 32'(res_valid), 32'h0);
        chk("rw_fifo_count", 32'(fifo_count), 32'h0);
        chk("rw_alu_s", 32'(alu_s), 32'h0);
        chk("rw_alu_x", 32'(alu_x), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);
        r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rw_no_valid", 32'(res_valid), 32'h0);
        end
        drive(4'h0, 16'h28, 16'h14);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("rw_add_valid", 32'(res_valid), 32'h1);
        chk("rw_add_z", res_z, 32'h3C);
        step();
        step();

        // simultaneous push and pop in HOLD
        res_ready = 1'b0;
        drive(4'h0, 16'h100, 16'h1);
        step();
        drive(4'h1, 16'h200, 16'h2);
        step();
        drive(4'h4, 16'h300, 16'h3);
        step();
        cmd_valid = 1'b0;
        step();
        chk("sp_pre_count", 32'(fifo_count), 32'd2);
        chk("sp_pre_valid", 32'(res_valid), 32'h1);
        res_ready = 1'b1;
        drive(4'h5, 16'h400, 16'h4);
        step();
        cmd_valid = 1'b0;
        chk("sp_count", 32'(fifo_count), 32'd2);
        chk("sp_next_x", 32'(alu_x), 32'h200);
        chk("sp_next_s", 32'(alu_s), 32'h1);
        for (int i = 0; i < 15; i++) step();

        // divide by zero
        drive(4'h3, 16'h28, 16'h0);
        step();
        cmd_valid = 1'b0;
`ifdef ALU_SEQ_DIV0_EN
        step();
        chk("d0_valid", 32'(res_valid), 32'h1);
        chk("d0_z", res_z, 32'hFFFF_FFFF);
        chk("d0_err", 32'(res_err), 32'h1);
        chk("d0_op", 32'(res_op), 32'h3);
        chk("d0_alu_s", 32'(alu_s), 32'h5);
        chk("d0_alu_x", 32'(alu_x), 32'h400);
        chk("d0_alu_y", 32'(alu_y), 32'h4);
`else
        step();
        step();
        step();
        chk("d0_valid", 32'(res_valid), 32'h1);
        chk("d0_z", res_z, 32'h0);
        chk("d0_err", 32'(res_err), 32'h0);
        chk("d0_op", 32'(res_op), 32'h3);
        chk("d0_alu_x", 32'(alu_x), 32'h28);
        chk("d0_alu_y", 32'(alu_y), 32'h0);
`endif
        step();
        drive(4'h0, 16'h1, 16'h1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // randomized soak
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 79) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 7))
                    0: cmd_op = 4'h0;
                    1: cmd_op = 4'h1;
                    2: cmd_op = 4'h2;
                    3, 4: cmd_op = 4'h3;
                    5: cmd_op = 4'hC;
                    default: cmd_op = 4'($urandom_range(0, 15));
                endcase
                cmd_valid = 1'b1;
                cmd_x = 16'($urandom);
                cmd_y = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        r = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("final_idle_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the 16-bit ALU (4-bit select s, operands X/Y, 32-bit result Z).
- Accepts {op, X, Y} commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU, holding s/X/Y stable until the result is captured.
- Returns each Z over a valid/ready result interface, in command order.

Parameters:
- DEPTH, 4: command FIFO depth; power of 2, minimum 2.
- ALU_LAT, 1: clock edges from ALU inputs changing to Z being valid; minimum 1.

Ports:
- c  in  1  clock, rising edge.
- r  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  ALU select code.
- cmd_x  in  16  operand X.
- cmd_y  in  16  operand Y.
- alu_s  out  4  to ALU s.
- alu_x  out  16  to ALU X.
- alu_y  out  16  to ALU Y.
- alu_z  in  32  from ALU Z.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_z  out  32  captured Z.
- res_op  out  4  op code of this result.
- res_err  out  1  error flag; see Optional Feature.
- busy  out  1  high unless state is IDLE and FIFO is empty.
- fifo_count  out  clog2(DEPTH)+1  number of queued commands.

Behaviour:
- Reset: clock is c; reset r is synchronous and active-high.
  - While r=1 at an edge, all registers clear: alu_s/alu_x/alu_y=0, res_valid=0, res_z=0, res_op=0, res_err=0, fifo_count=0, state=IDLE.
  - FIFO pointers clear.
  - cmd_ready=0 whenever r=1.
- Push: accepted at an edge when cmd_valid & cmd_ready. cmd_ready = ~r & (fifo_count<DEPTH), combinational from registered count.
- No bypass: a command pushed into an empty FIFO is issued at the next edge at the earliest.
- Simultaneous push and pop: allowed. fifo_count is unchanged, and the write and read pointers both advance, wrapping mod DEPTH.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if FIFO is non-empty at an edge, pop the head, load alu_s/x/y, load lat_cnt=ALU_LAT, go to WAIT. Otherwise stay.
  - WAIT: alu_s/x/y are held. lat_cnt decrements each edge. At the edge where lat_cnt==0:
    - capture res_z<=alu_z and res_op<=alu_s;
    - set res_valid<=1;
    - go to HOLD.
    - The capture edge is issue_edge+ALU_LAT+1.
  - HOLD: res_valid=1 and res_z/res_op are stable until an edge with res_ready=1. At that edge:
    - if FIFO non-empty: pop and issue the next command in the same edge, res_valid<=0, go to WAIT;
    - if FIFO empty: res_valid<=0, go to IDLE.
- alu_s/x/y keep their last issued values when idle; they are not zeroed.
- Latency with ALU_LAT=1:
  - command accepted at edge A → issued at A+1 → captured at A+3;
  - res_valid is visible in the cycle after A+3.
- Throughput: one result every ALU_LAT+2 edges when res_ready is held high.
- Backpressure: with res_ready=0, the sequencer holds 1 command in flight plus DEPTH queued. cmd_ready then falls.
- Reset mid-operation (any state): the in-flight result and all queued commands are discarded, and no res_valid pulse follows.
- Commands are never dropped or reordered. res_valid never falls without the handshake (except on reset).

Optional Feature:
- Macro: ALU_SEQ_DIV0_EN.
- Defined: a command with op=4'h3 and Y=16'h0 is not issued to the ALU.
  - It is popped in IDLE or HOLD and goes straight to HOLD at that edge with res_z=32'hFFFF_FFFF, res_op=3, res_err=1.
  - alu_s/x/y are not updated.
  - res_err is cleared on every normal capture.
- Undefined: divide-by-zero is issued like any other command, and res_err is tied to 0.

Test Plan:
- Reset then single add: after r, push op=0, X=16'h28, Y=16'h14; hold res_ready=1 → res_valid is seen 3 edges after accept with res_z=32'h3C, res_op=0.
- Stream with res_ready=1: push ops 1, 2, 3, 12 with X=16'h28, Y=16'h14 back-to-back → results in order 32'h14, 32'h320, 32'h2, 32'h3C, one result every 3 edges.
- Backpressure, DEPTH=4, res_ready=0: push 6 commands every cycle → 5 accepted, cmd_ready=0 with fifo_count=4. First result held stable; releasing res_ready drains all 5 in order.
- Reset mid-WAIT: issue a mul, assert r for 1 cycle during WAIT → all outputs at reset values, fifo_count=0, no res_valid afterwards. A following add 16'h28+16'h14 returns 32'h3C.
- Simultaneous push/pop: with fifo_count=2 in HOLD, pulse res_ready and push in the same edge → fifo_count stays 2 and the next issue is the oldest queued command.
- Div-by-zero (ALU_SEQ_DIV0_EN defined): op=3, X=16'h28, Y=0 → res_z=32'hFFFF_FFFF, res_err=1, alu_s/x/y unchanged. Macro undefined → ALU result is passed through and res_err=0.
